// File: rtl/stream_width_downsizer.sv
// Wide-to-narrow stream serialiser: each accepted IN_WIDTH word leaves as RATIO
// OUT_WIDTH beats, least-significant slice first, with in_last carried onto the final beat.
module stream_width_downsizer #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OUT_WIDTH*RATIO-1:0]     in_data,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int BW       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [BW-1:0] ONE_BEAT  = BW'(1);

  logic [IN_WIDTH-1:0] word_q, word_d;
  logic                last_q, last_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                valid_q, valid_d;

  logic at_last_beat;
  logic rx;
  logic tx;

  assign at_last_beat = (beat_q == LAST_BEAT);

  // Combinational out_ready -> in_ready lets a new word load on the final beat
  // with no bubble; the upstream skid buffer registers this path.
  assign in_ready = !reset && (!valid_q || (out_ready && at_last_beat));
  assign rx       = in_valid && in_ready;
  assign tx       = valid_q && out_ready;

  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (rx) begin
      word_d  = in_data;
      last_d  = in_last;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (tx) begin
      if (at_last_beat) begin
        beat_d  = '0;
        valid_d = 1'b0;
      end else begin
        beat_d  = beat_q + ONE_BEAT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = word_q[int'(beat_q)*OUT_WIDTH +: OUT_WIDTH];
  assign out_last  = valid_q && last_q && at_last_beat;

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Scoreboard bench for stream_width_downsizer: the driver queues expected beats on
// every accepted word, a free-running monitor checks each presented beat against the queue.
module tb_stream_width_downsizer;

  localparam int OW    = 8;
  localparam int RATIO = 4;
  localparam int IW    = OW * RATIO;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    int            idx;
  } beat_t;

  beat_t sb[$];

  stream_width_downsizer #(.OUT_WIDTH(OW), .RATIO(RATIO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word splits into RATIO slices, low slice first, last flag only on the final slice.
  task automatic push_word(input logic [IW-1:0] w, input logic l);
    for (int i = 0; i < RATIO; i++) begin
      beat_t b;
      b.d   = w[i*OW +: OW];
      b.l   = l && (i == RATIO - 1);
      b.idx = i;
      sb.push_back(b);
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [IW-1:0] d, input logic l,
                             input logic r, output logic rx);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    rx = in_valid && in_ready;
    @(posedge clk);
    if (rx) push_word(d, l);
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic l, input logic r);
    logic rx;
    int   n;
    rx = 1'b0;
    n  = 0;
    while (!rx && n < 20) begin
      drive_cycle(1'b1, d, l, r, rx);
      n++;
    end
    if (!rx) check("accept_timeout", 64'(n), 64'(0));
  endtask

  task automatic idle(input int n, input logic r);
    logic rx;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, r, rx);
  endtask

  // Monitor: independent of the driver, pops one expected beat per transfer.
  always begin
    logic exp_valid;
    logic exp_rdy;
    @(negedge clk);
    #2;
    exp_valid = (sb.size() != 0);
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (reset) exp_rdy = 1'b0;
    else if (!exp_valid) exp_rdy = 1'b1;
    else exp_rdy = out_ready && (sb[0].idx == RATIO - 1);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid && exp_valid) begin
      check("out_data", 64'(out_data), 64'(sb[0].d));
      check("out_last", 64'(out_last), 64'(sb[0].l));
      if (out_ready) void'(sb.pop_front());
    end
  end

  initial begin
    logic rx;
    logic [IW-1:0] w;
    logic          wl;
    int            n;

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hCAFEF00D;
    in_last   = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);

    // single word, full throughput downstream
    send_word(32'hDDCCBBAA, 1'b1, 1'b1);
    idle(6, 1'b1);

    // back-to-back words must produce contiguous beats
    send_word(32'h03020100, 1'b0, 1'b1);
    send_word(32'h07060504, 1'b1, 1'b1);
    idle(6, 1'b1);

    // backpressure while BB is shown
    send_word(32'hDDCCBBAA, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, rx);
    repeat (3) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, rx);
      #1;
      check("hold_data", 64'(out_data), 64'h BB);
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, rx);
    #1;
    check("after_hold_data", 64'(out_data), 64'h CC);
    idle(6, 1'b1);

    // asynchronous reset pulse while CC is shown
    send_word(32'hDDCCBBAA, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, rx);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, rx);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pre_rst_data", 64'(out_data), 64'h CC);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_data", 64'(out_data), 64'(0));
    sb.delete();
    #1;
    reset = 1'b0;
    @(posedge clk);
    send_word(32'h44332211, 1'b1, 1'b1);
    idle(6, 1'b1);

    // randomized traffic with random backpressure
    n = 0;
    while (n < 300) begin
      w  = $urandom;
      wl = 1'($urandom_range(0, 1));
      rx = 1'b0;
      while (!rx && n < 300) begin
        drive_cycle(1'($urandom_range(0, 3) != 0), w, wl, 1'($urandom_range(0, 3) != 0), rx);
        n++;
      end
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1, rx);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
